// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int QDEPTH_DEFAULT = 2;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } if_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO of fetched entries with flush; head is read straight from storage.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  if_entry_t                push_data,
  output if_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW:0]   count_reg;
  if_entry_t     mem_reg [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  // Storage is cleared on reset so the stale head reads as zero afterwards.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (srst) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch queue and redirect handling.
// Optional IF_MISALIGN_CHECK_EN: misaligned redirects emit one faulting NOP then halt fetch.
module if_stage
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [63:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_misalign_o
);

  logic [63:0]            pc_reg;
  if_state_e              state_reg;
  if_entry_t              push_data;
  if_entry_t              head;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(QDEPTH):0] fifo_count;

`ifdef IF_MISALIGN_CHECK_EN
  logic halt_done_reg;
`endif

  always_comb begin
    push      = (state_reg == RUN) && !fifo_full && !redirect_valid_i;
    push_data = '{pc: pc_reg, instr: imem_data_i, misalign: 1'b0};
`ifdef IF_MISALIGN_CHECK_EN
    // In HALT exactly one faulting NOP is queued, waiting for space if needed.
    if (state_reg == HALT) begin
      push      = !halt_done_reg && !fifo_full && !redirect_valid_i;
      push_data = '{pc: pc_reg, instr: NOP_INSTR, misalign: 1'b1};
    end
`endif
  end

  assign pop = if_valid_o && if_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_reg    <= RESET_PC;
      state_reg <= RUN;
`ifdef IF_MISALIGN_CHECK_EN
      halt_done_reg <= 1'b0;
`endif
    end else if (redirect_valid_i) begin
`ifdef IF_MISALIGN_CHECK_EN
      pc_reg        <= redirect_pc_i;
      state_reg     <= (redirect_pc_i[1:0] != 2'b00) ? HALT : RUN;
      halt_done_reg <= 1'b0;
`else
      pc_reg    <= {redirect_pc_i[63:2], 2'b00};
      state_reg <= RUN;
`endif
    end else if (push) begin
`ifdef IF_MISALIGN_CHECK_EN
      if (state_reg == HALT) halt_done_reg <= 1'b1;
      else                   pc_reg <= pc_reg + 64'd4;
`else
      pc_reg <= pc_reg + 64'd4;
`endif
    end
  end

  if_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .srst      (rst_i),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid_i),
    .push_data (push_data),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign imem_addr_o = pc_reg;
  assign if_valid_o  = !fifo_empty;
  assign if_pc_o     = head.pc;
  assign if_instr_o  = head.instr;

`ifdef IF_MISALIGN_CHECK_EN
  assign if_misalign_o = head.misalign;
  logic unused_bits;
  assign unused_bits = ^fifo_count;
`else
  assign if_misalign_o = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{fifo_count, redirect_pc_i[1:0], head.misalign};
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected decode handoffs queued by stimulus, checked by a monitor.
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  int passed = 0;
  int total  = 0;
  if_entry_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h00500093;
      64'h4:   return 32'h00a00113;
      64'h8:   return 32'h002081b3;
      default: return a[31:0] ^ 32'h5a5a0003;
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  if_stage #(.RESET_PC(64'h0), .QDEPTH(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_addr_o      (imem_addr),
    .imem_data_i      (imem_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_pc_o          (if_pc),
    .if_instr_o       (if_instr),
    .if_misalign_o    (if_misalign)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [63:0] pc, input logic [31:0] instr, input logic mis);
    exp_q.push_back('{pc: pc, instr: instr, misalign: mis});
  endtask

  // Leaves the bench in cycle 0 after reset release, with decode stalled.
  task automatic do_reset();
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Monitor: every accepted handoff must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_pc", if_pc, 64'hdead_dead_dead_dead);
      end else begin
        if_entry_t e;
        e = exp_q.pop_front();
        check("pop_pc", if_pc, e.pc);
        check("pop_instr", {32'h0, if_instr}, {32'h0, e.instr});
        check("pop_misalign", {63'h0, if_misalign}, {63'h0, e.misalign});
      end
    end
  end

  initial begin
    // Reset state
    rst = 1'b1;
    step(2);
    check("rst_imem_addr", imem_addr, 64'h0);
    check("rst_valid", {63'h0, if_valid}, 64'h0);
    check("rst_pc", if_pc, 64'h0);
    check("rst_instr", {32'h0, if_instr}, 64'h0);
    rst = 1'b0;

    // Streaming with decode always ready
    do_reset();
    if_ready = 1'b1;
    expect_entry(64'h0, 32'h00500093, 1'b0);
    expect_entry(64'h4, 32'h00a00113, 1'b0);
    expect_entry(64'h8, 32'h002081b3, 1'b0);
    check("t1_c0_addr", imem_addr, 64'h0);
    check("t1_c0_valid", {63'h0, if_valid}, 64'h0);
    step(1);
    check("t1_c1_valid", {63'h0, if_valid}, 64'h1);
    check("t1_c1_pc", if_pc, 64'h0);
    step(1);
    check("t1_c2_valid", {63'h0, if_valid}, 64'h1);
    check("t1_c2_pc", if_pc, 64'h4);
    step(1);
    check("t1_c3_valid", {63'h0, if_valid}, 64'h1);
    check("t1_c3_pc", if_pc, 64'h8);
    step(1);
    if_ready = 1'b0;

    // Backpressure: queue fills, fetch address holds
    do_reset();
    step(3);
    check("t2_c3_addr", imem_addr, 64'h8);
    step(2);
    check("t2_c5_addr", imem_addr, 64'h8);
    check("t2_c5_valid", {63'h0, if_valid}, 64'h1);
    check("t2_c5_pc", if_pc, 64'h0);
    expect_entry(64'h0, 32'h00500093, 1'b0);
    expect_entry(64'h4, 32'h00a00113, 1'b0);
    expect_entry(64'h8, 32'h002081b3, 1'b0);
    if_ready = 1'b1;
    step(3);
    if_ready = 1'b0;

    // Redirect in a cycle where the head is popped
    do_reset();
    if_ready = 1'b1;
    expect_entry(64'h0, 32'h00500093, 1'b0);
    expect_entry(64'h4, 32'h00a00113, 1'b0);
    expect_entry(64'h100, rom(64'h100), 1'b0);
    step(2);
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    step(1);
    redirect_valid = 1'b0;
    check("t3_addr_target", imem_addr, 64'h100);
    check("t3_bubble", {63'h0, if_valid}, 64'h0);
    step(1);
    check("t3_target_valid", {63'h0, if_valid}, 64'h1);
    check("t3_target_pc", if_pc, 64'h100);
    step(1);
    if_ready = 1'b0;

    // PC wraps past the top of the address space
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    check("t4_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1);
    check("t4_addr_wrap", imem_addr, 64'h0);
    check("t4_head_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_entry(64'hFFFF_FFFF_FFFF_FFFC, rom(64'hFFFF_FFFF_FFFF_FFFC), 1'b0);
    expect_entry(64'h0, 32'h00500093, 1'b0);
    if_ready = 1'b1;
    step(2);
    if_ready = 1'b0;

    // Misaligned redirect target
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 64'h102;
    step(1);
    redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    check("t5_addr_mis", imem_addr, 64'h102);
    step(1);
    check("t5_mis_valid", {63'h0, if_valid}, 64'h1);
    check("t5_mis_flag", {63'h0, if_misalign}, 64'h1);
    expect_entry(64'h102, NOP_INSTR, 1'b1);
    if_ready = 1'b1;
    step(1);
    check("t5_halt_empty", {63'h0, if_valid}, 64'h0);
    check("t5_halt_addr", imem_addr, 64'h102);
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    step(1);
    redirect_valid = 1'b0;
    check("t5_resume_addr", imem_addr, 64'h200);
    expect_entry(64'h200, rom(64'h200), 1'b0);
    step(1);
    check("t5_resume_pc", if_pc, 64'h200);
    step(1);
    if_ready = 1'b0;
`else
    check("t5_addr_aligned", imem_addr, 64'h100);
    step(1);
    check("t5_valid", {63'h0, if_valid}, 64'h1);
    check("t5_no_mis", {63'h0, if_misalign}, 64'h0);
    expect_entry(64'h100, rom(64'h100), 1'b0);
    if_ready = 1'b1;
    step(1);
    if_ready = 1'b0;
`endif

    // Reset beats a simultaneous redirect
    do_reset();
    step(4);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h300;
    step(1);
    check("t6_addr", imem_addr, 64'h0);
    check("t6_valid", {63'h0, if_valid}, 64'h0);
    check("t6_pc", if_pc, 64'h0);
    check("t6_instr", {32'h0, if_instr}, 64'h0);
    check("t6_mis", {63'h0, if_misalign}, 64'h0);
    rst = 1'b0;
    redirect_valid = 1'b0;
    step(1);
    check("t6_restart_pc", if_pc, 64'h0);
    check("t6_restart_addr", imem_addr, 64'h4);

    step(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the rv64 core. It owns the program counter and drives the word address into the combinational instruction memory. It captures the returned 32-bit instruction together with its PC in a small instruction queue, and hands entries to decode over a valid/ready handshake. Branch/jump redirects from downstream flush the queue and restart fetch at the target.

## Interface
- RESET_PC, 64'h0, PC loaded on reset.
- QDEPTH, 2, instruction-queue entries; power of two, ≥2.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_addr_o  out  64  fetch address (current PC) to instruction memory.
- imem_data_i  in  32  instruction word for imem_addr_o, same cycle (combinational memory).
- redirect_valid_i  in  1  flush and restart at redirect_pc_i.
- redirect_pc_i  in  64  redirect target.
- if_valid_o  out  1  queue head valid.
- if_ready_i  in  1  decode accepts head.
- if_pc_o  out  64  PC of head entry.
- if_instr_o  out  32  instruction of head entry.
- if_misalign_o  out  1  head entry carries an instruction-address-misaligned fault.

## Operation
- State: pc_q (64b), queue (QDEPTH entries of {pc, instr, misalign}), count, rd/wr pointers, FSM {RUN, HALT}.
- imem_addr_o = pc_q, always, including in HALT.
- push = (state==RUN) && (count < QDEPTH) && !redirect_valid_i; pushes {pc_q, imem_data_i, 0}; pc_q <= pc_q + 4, wrapping mod 2^64.
- pop = if_valid_o && if_ready_i; advances rd pointer.
- Push and pop in the same cycle: count unchanged. No bypass: a full queue does not accept a push even when popping that cycle.
- if_valid_o = (count != 0). Head fields come straight from the queue storage. When count==0, outputs show the stale head slot.
- Redirect (highest priority): queue emptied (count 0, pointers 0), pc_q <= redirect_pc_i, state <= RUN. A pop in the same cycle still counts as consumed by decode. No push that cycle.
- Reset: pc_q=RESET_PC, count=0, pointers 0, state RUN. Outputs: imem_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=0, if_misalign_o=0 (storage cleared).
- Reset mid-operation discards all entries and overrides a same-cycle redirect.

## Timing
- Cycle 0 after reset release: imem_addr_o=RESET_PC, push. Cycle 1: if_valid_o=1, if_pc_o=RESET_PC.
- Fetch-to-decode latency: 1 cycle. Sustained throughput: 1 instr/cycle while if_ready_i=1 (count stays 1).
- Redirect asserted in cycle N: cycle N+1 imem_addr_o=target, if_valid_o=0. Cycle N+2 head = target entry.
- With if_ready_i=0 the queue fills after QDEPTH cycles. pc_q then holds and imem_addr_o is stable.
- if_ready_i may change freely. Once if_valid_o=1, the head fields are held stable until pop or redirect.

## Configuration
- IF_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0]!=0 loads pc_q=redirect_pc_i and sets state=HALT.
  - Next cycle, one entry {pc_q, 32'h00000013, misalign=1} is pushed, and further pushes stop until the next redirect or reset.
  - If the queue is full, that push waits.
- Not defined:
  - redirect_pc_i[1:0] are ignored (pc_q <= {redirect_pc_i[63:2], 2'b00}).
  - HALT is unreachable and if_misalign_o is tied 0.

## Structure
- Shared package if_pkg holds:
  - NOP_INSTR = 32'h00000013.
  - Struct if_entry_t {pc[63:0], instr[31:0], misalign}.
  - Enum if_state_e {RUN, HALT}.
  - Default QDEPTH.
- Sub-module if_fifo: parameterised synchronous FIFO of if_entry_t with push/pop/flush, count, full/empty. PC/FSM logic stays in if_stage.

## Test plan
- Reset with RESET_PC=0, if_ready_i=1, ROM words 00500093, 00a00113, 002081b3 → if_pc_o 0,4,8 on cycles 1,2,3 with matching if_instr_o; no bubbles.
- if_ready_i=0 for 5 cycles from reset → count saturates at 2, imem_addr_o holds 0x8. Release → entries 0x0, 0x4, 0x8 delivered in order, no loss or duplication.
- Redirect to 0x100 in a cycle where the head is being popped → popped entry consumed once, queue flushed. Next valid entry is pc 0x100 two cycles later.
- pc_q=0xFFFF_FFFF_FFFF_FFFC → next fetch address 0x0.
- IF_MISALIGN_CHECK_EN, redirect to 0x102 → single entry pc=0x102, instr=0x00000013, if_misalign_o=1, then if_valid_o=0. A redirect to 0x200 resumes normal fetch.
- Redirect and rst_i asserted together → state equals plain reset, imem_addr_o=RESET_PC.
